// File: rtl/vector_normalize_stream_pkg.sv
// ---------------------------------------------------------------------------
// vector_norm_pkg
// Shared definitions for the streaming vector normaliser:
//   - default geometry (VN_W / VN_FRAC_W / VN_N / VN_TAG_W)
//   - one()    : fixed-point 1.0 for a given fraction width
//   - fx_mul() : (a*b) >>> frac with signed-range overflow detection
//   - vn_stage_t : pipeline stage record {valid, vec, scale, zero, tag}
// Optional feature macro used by the top: VECTOR_NORMALIZE_STREAM_BACKPRESSURE_EN
// ---------------------------------------------------------------------------
package vector_norm_pkg;

    localparam int VN_W      = 16;
    localparam int VN_FRAC_W = 8;
    localparam int VN_N      = 3;
    localparam int VN_TAG_W  = 4;

    // Operand width of the generic multiply helper; widths up to 32 bits.
    localparam int MAX_W  = 32;
    localparam int PROD_W = 2 * MAX_W;

    typedef struct packed {
        logic                        valid;
        logic [VN_N*VN_W-1:0]        vec;
        logic [VN_W-1:0]             scale;
        logic                        zero;
        logic [VN_TAG_W-1:0]         tag;
    } vn_stage_t;

    typedef struct packed {
        logic                        ovf;
        logic signed [MAX_W-1:0]     val;
    } fx_mul_t;

    // Fixed-point 1.0 for frac_w fraction bits.
    function automatic logic [MAX_W-1:0] one(input int frac_w);
        logic [MAX_W-1:0] unit;
        unit = {{(MAX_W-1){1'b0}}, 1'b1};
        return unit << frac_w;
    endfunction

    // Signed fixed-point multiply, truncated toward -inf, with a flag set
    // when the shifted product leaves the signed w-bit range.
    function automatic fx_mul_t fx_mul(input logic signed [MAX_W-1:0] a,
                                       input logic signed [MAX_W-1:0] b,
                                       input int                      w,
                                       input int                      frac);
        logic signed [PROD_W-1:0] prod;
        logic signed [PROD_W-1:0] shifted;
        logic signed [PROD_W-1:0] lim;
        fx_mul_t                  res;
        prod    = PROD_W'(a) * PROD_W'(b);
        shifted = prod >>> frac;
        lim     = 64'sd1 <<< (w - 1);
        res.ovf = (shifted > (lim - 64'sd1)) || (shifted < -lim);
        res.val = MAX_W'(shifted);
        return res;
    endfunction

endpackage

// File: rtl/vector_normalize_stream_if.sv
// ---------------------------------------------------------------------------
// vector_normalize_stream_if
// Input and output valid/ready channels of the vector normaliser.
//   in_valid/in_ready/in_vec/in_tag              : vector input channel
//   out_valid/out_ready/out_vec/out_scale/
//   out_zero/out_tag                             : result channel
// slave  : the normaliser side; master : the producer/consumer side.
// ---------------------------------------------------------------------------
interface vector_normalize_stream_if #(
    parameter int W     = 16,
    parameter int N     = 3,
    parameter int TAG_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [N*W-1:0]     in_vec;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [N*W-1:0]     out_vec;
    logic [W-1:0]       out_scale;
    logic               out_zero;
    logic [TAG_W-1:0]   out_tag;

    modport slave (
        input  in_valid, in_vec, in_tag, out_ready,
        output in_ready, out_valid, out_vec, out_scale, out_zero, out_tag
    );

    modport master (
        output in_valid, in_vec, in_tag, out_ready,
        input  in_ready, out_valid, out_vec, out_scale, out_zero, out_tag
    );
endinterface

// File: rtl/vector_normalize_stream_stage.sv
// ---------------------------------------------------------------------------
// vnorm_stage
// One step of the MSB-first scale search. Tries candidate c = in_scale | TEST_BIT,
// forms dot(c*v, c*v) and keeps the bit when no multiply overflows and the
// dot product stays within [0, 1.0]. Result is registered with advance.
// Ports: clk, rst (async, active-high), advance (pipeline enable),
//        in_* : stage g record, out_* : stage g+1 record.
// ---------------------------------------------------------------------------
module vnorm_stage
    import vector_norm_pkg::*;
#(
    parameter int             W        = VN_W,
    parameter int             FRAC_W   = VN_FRAC_W,
    parameter int             N        = VN_N,
    parameter int             TAG_W    = VN_TAG_W,
    parameter logic [W-1:0]   TEST_BIT = {1'b0, 1'b1, {(W-2){1'b0}}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              in_valid,
    input  logic [N*W-1:0]    in_vec,
    input  logic [W-1:0]      in_scale,
    input  logic              in_zero,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    output logic [N*W-1:0]    out_vec,
    output logic [W-1:0]      out_scale,
    output logic              out_zero,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int ACC_W = W + $clog2(N);
    localparam logic [ACC_W-1:0] DOT_MAX = ACC_W'({(W-1){1'b1}});
    localparam logic [ACC_W-1:0] ONE_ACC = ACC_W'(one(FRAC_W));

    logic [W-1:0]      cand_s;
    logic [W-1:0]      next_scale_s;
    fx_mul_t           prod_s;
    fx_mul_t           sq_s;
    logic              ovf_s;
    logic              keep_s;
    logic [ACC_W-1:0]  dot_s;

    // Candidate evaluation: component products, their squares and the dot sum.
    always_comb begin
        cand_s = in_scale | TEST_BIT;
        prod_s = '0;
        sq_s   = '0;
        ovf_s  = 1'b0;
        dot_s  = '0;
        for (int i = 0; i < N; i++) begin
            prod_s = fx_mul(MAX_W'($signed(in_vec[i*W +: W])), MAX_W'($signed(cand_s)), W, FRAC_W);
            // Squaring reuses the full product; a bad product is already flagged.
            sq_s   = fx_mul(prod_s.val, prod_s.val, W, FRAC_W);
            ovf_s  = ovf_s | prod_s.ovf | sq_s.ovf;
            dot_s  = dot_s + ACC_W'($unsigned(W'(sq_s.val)));
        end
        keep_s = ~ovf_s & (dot_s <= DOT_MAX) & (dot_s <= ONE_ACC);
        if (keep_s) begin
            next_scale_s = cand_s;
        end else begin
            next_scale_s = in_scale;
        end
    end

    // Stage register, held while the pipeline is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_vec   <= '0;
            out_scale <= '0;
            out_zero  <= 1'b0;
            out_tag   <= '0;
        end else if (advance) begin
            out_valid <= in_valid;
            out_vec   <= in_vec;
            out_scale <= next_scale_s;
            out_zero  <= in_zero;
            out_tag   <= in_tag;
        end
    end

endmodule

// File: rtl/vector_normalize_stream.sv
// ---------------------------------------------------------------------------
// vector_normalize_stream
// Streaming fixed-point vector normaliser. For each input vector v finds the
// largest s >= 0 with dot(s*v, s*v) <= 1.0 (MSB-first, W-1 search stages) and
// returns s*v, s, a zero-vector flag and the input tag W cycles later.
// Ports: clk, rst (async, active-high),
//        bus : vector_normalize_stream_if.slave (input and result channels).
// Macro VECTOR_NORMALIZE_STREAM_BACKPRESSURE_EN: when defined, out_ready
// stalls the whole pipe; otherwise the pipe free-runs and in_ready is 1.
// ---------------------------------------------------------------------------
module vector_normalize_stream
    import vector_norm_pkg::*;
#(
    parameter int W      = VN_W,
    parameter int FRAC_W = VN_FRAC_W,
    parameter int N      = VN_N,
    parameter int TAG_W  = VN_TAG_W
) (
    input  logic                       clk,
    input  logic                       rst,
    vector_normalize_stream_if.slave   bus
);

    // Index 0 is the input register (s_0 = 0); index g+1 is the output of
    // search stage g, so index W-1 carries the final scale.
    logic                valid_c [W];
    logic [N*W-1:0]      vec_c   [W];
    logic [W-1:0]        scale_c [W];
    logic                zero_c  [W];
    logic [TAG_W-1:0]    tag_c   [W];

    logic                advance_s;
    logic signed [2*W-1:0] prod_s;
    logic [N*W-1:0]      out_vec_s;

    logic                out_valid_r;
    logic [N*W-1:0]      out_vec_r;
    logic [W-1:0]        out_scale_r;
    logic                out_zero_r;
    logic [TAG_W-1:0]    out_tag_r;

`ifdef VECTOR_NORMALIZE_STREAM_BACKPRESSURE_EN
    assign advance_s = ~out_valid_r | bus.out_ready;
`else
    assign advance_s = 1'b1;
`endif

    assign bus.in_ready  = advance_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_vec   = out_vec_r;
    assign bus.out_scale = out_scale_r;
    assign bus.out_zero  = out_zero_r;
    assign bus.out_tag   = out_tag_r;

    assign scale_c[0] = '0;

    // Input register; the zero-vector flag is decided here and carried along.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_c[0] <= 1'b0;
            vec_c[0]   <= '0;
            zero_c[0]  <= 1'b0;
            tag_c[0]   <= '0;
        end else if (advance_s) begin
            valid_c[0] <= bus.in_valid;
            vec_c[0]   <= bus.in_vec;
            zero_c[0]  <= (bus.in_vec == '0);
            tag_c[0]   <= bus.in_tag;
        end
    end

    for (genvar g = 0; g < W - 1; g++) begin : g_stage
        vnorm_stage #(
            .W        (W),
            .FRAC_W   (FRAC_W),
            .N        (N),
            .TAG_W    (TAG_W),
            .TEST_BIT (W'(1'b1) << (W - 2 - g))
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .advance   (advance_s),
            .in_valid  (valid_c[g]),
            .in_vec    (vec_c[g]),
            .in_scale  (scale_c[g]),
            .in_zero   (zero_c[g]),
            .in_tag    (tag_c[g]),
            .out_valid (valid_c[g+1]),
            .out_vec   (vec_c[g+1]),
            .out_scale (scale_c[g+1]),
            .out_zero  (zero_c[g+1]),
            .out_tag   (tag_c[g+1])
        );
    end

    // Final s*v; the search guarantees every component fits in W bits.
    always_comb begin
        prod_s    = '0;
        out_vec_s = '0;
        for (int i = 0; i < N; i++) begin
            prod_s = (2*W)'($signed(vec_c[W-1][i*W +: W])) * (2*W)'($signed(scale_c[W-1]));
            out_vec_s[i*W +: W] = W'(prod_s >>> FRAC_W);
        end
    end

    // Output register; holds its contents while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_vec_r   <= '0;
            out_scale_r <= '0;
            out_zero_r  <= 1'b0;
            out_tag_r   <= '0;
        end else if (advance_s) begin
            out_valid_r <= valid_c[W-1];
            out_vec_r   <= out_vec_s;
            out_scale_r <= scale_c[W-1];
            out_zero_r  <= zero_c[W-1];
            out_tag_r   <= tag_c[W-1];
        end
    end

endmodule

// File: tb/tb_vector_normalize_stream.sv
// ---------------------------------------------------------------------------
// tb_vector_normalize_stream
// Directed bench for vector_normalize_stream (W=16, FRAC_W=8, N=3): reset
// values, latency, known vectors, streaming, stall/free-run behaviour and
// mid-stream reset. Expected results are hand-computed table entries.
// ---------------------------------------------------------------------------
module tb_vector_normalize_stream;

    localparam int W      = 16;
    localparam int FRAC_W = 8;
    localparam int N      = 3;
    localparam int TAG_W  = 4;
    localparam int LAT    = 16;
`ifdef VECTOR_NORMALIZE_STREAM_BACKPRESSURE_EN
    localparam int STALL_RESULTS = 0;
`else
    localparam int STALL_RESULTS = 5;
`endif

    typedef struct packed {
        logic [N*W-1:0]   vec;
        logic [W-1:0]     scale;
        logic             zero;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int   n_checks  = 0;
    int   n_errors  = 0;
    int   n_results = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [N*W-1:0] tv_vec   [6];
    logic [N*W-1:0] tv_out   [6];
    logic [W-1:0]   tv_scale [6];
    logic           tv_zero  [6];

    always #5 clk = ~clk;

    vector_normalize_stream_if #(.W(W), .N(N), .TAG_W(TAG_W)) bus ();

    vector_normalize_stream #(
        .W      (W),
        .FRAC_W (FRAC_W),
        .N      (N),
        .TAG_W  (TAG_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard: every transferred result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && (bus.out_ready || STALL_RESULTS != 0)) begin
            n_results++;
            check_eq("result_pending", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check_eq("out_vec",   bus.out_vec,   mon_e.vec);
                check_eq("out_scale", bus.out_scale, mon_e.scale);
                check_eq("out_zero",  bus.out_zero,  mon_e.zero);
                check_eq("out_tag",   bus.out_tag,   mon_e.tag);
            end
        end
    end

    task automatic send(input int idx, input logic [TAG_W-1:0] tag);
        bit   rdy;
        int   guard;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_vec   = tv_vec[idx];
        bus.in_tag   = tag;
        rdy   = 1'b0;
        guard = 0;
        while (!rdy && guard < 100) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (rdy) begin
            e.vec   = tv_out[idx];
            e.scale = tv_scale[idx];
            e.zero  = tv_zero[idx];
            e.tag   = tag;
            exp_q.push_back(e);
        end else begin
            check_eq("accept_timeout", 64'(rdy), 64'd1);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic timed_send(input int idx, input logic [TAG_W-1:0] tag, input string name);
        int k;
        bit seen;
        send(idx, tag);
        idle();
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            seen = bus.out_valid;
        end
        check_eq(name, 64'(k), 64'(LAT));
        @(posedge clk);
        #1;
        check_eq("valid_pulse", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic stall_test(input int base);
        int k;
        int start;
        logic [N*W-1:0]   snap_vec;
        logic [W-1:0]     snap_scale;
        logic [TAG_W-1:0] snap_tag;
        k = 0;
        while (n_results < base + 3 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("stall_reached", 64'(n_results >= base + 3), 64'd1);
        bus.out_ready = 1'b0;
        start = n_results;
        snap_vec   = '0;
        snap_scale = '0;
        snap_tag   = '0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
`ifdef VECTOR_NORMALIZE_STREAM_BACKPRESSURE_EN
            check_eq("stall_in_ready", 64'(bus.in_ready), 64'd0);
            check_eq("stall_out_valid", 64'(bus.out_valid), 64'd1);
            if (j == 0) begin
                snap_vec   = bus.out_vec;
                snap_scale = bus.out_scale;
                snap_tag   = bus.out_tag;
            end else begin
                check_eq("stall_vec_stable",   bus.out_vec,   snap_vec);
                check_eq("stall_scale_stable", bus.out_scale, snap_scale);
                check_eq("stall_tag_stable",   bus.out_tag,   snap_tag);
            end
`else
            check_eq("free_in_ready", 64'(bus.in_ready), 64'd1);
`endif
        end
        @(posedge clk);
        #1;
        check_eq("stall_results", 64'(n_results - start), 64'(STALL_RESULTS));
        bus.out_ready = 1'b1;
    endtask

    initial begin
        int base;
        int stale;

        // (3,4,0) -> s = 0x33: 9c^2/256 + 16c^2/256 <= 256 holds up to c = 51
        tv_vec[0] = {16'h0000, 16'h0400, 16'h0300};
        tv_out[0] = {16'h0000, 16'h00CC, 16'h0099};  tv_scale[0] = 16'h0033; tv_zero[0] = 1'b0;
        // (-3,4,0): same magnitudes, product -153 = 0xFF67
        tv_vec[1] = {16'h0000, 16'h0400, 16'hFD00};
        tv_out[1] = {16'h0000, 16'h00CC, 16'hFF67};  tv_scale[1] = 16'h0033; tv_zero[1] = 1'b0;
        // unit vector: 256^2/256 = 256 accepted, 257 gives 258
        tv_vec[2] = {16'h0000, 16'h0000, 16'h0100};
        tv_out[2] = {16'h0000, 16'h0000, 16'h0100};  tv_scale[2] = 16'h0100; tv_zero[2] = 1'b0;
        // zero vector: every bit kept
        tv_vec[3] = {16'h0000, 16'h0000, 16'h0000};
        tv_out[3] = {16'h0000, 16'h0000, 16'h0000};  tv_scale[3] = 16'h7FFF; tv_zero[3] = 1'b1;
        // 100.0: s=2 -> 200, 40000/256=156; s=3 -> 351 rejected
        tv_vec[4] = {16'h0000, 16'h0000, 16'h6400};
        tv_out[4] = {16'h0000, 16'h0000, 16'h00C8};  tv_scale[4] = 16'h0002; tv_zero[4] = 1'b0;
        // (0,3,4): exercises components 1 and 2
        tv_vec[5] = {16'h0400, 16'h0300, 16'h0000};
        tv_out[5] = {16'h00CC, 16'h0099, 16'h0000};  tv_scale[5] = 16'h0033; tv_zero[5] = 1'b0;

        bus.in_valid  = 1'b0;
        bus.in_vec    = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_out_vec",   bus.out_vec,   64'd0);
        check_eq("rst_out_scale", bus.out_scale, 64'd0);
        check_eq("rst_out_zero",  64'(bus.out_zero), 64'd0);
        check_eq("rst_out_tag",   bus.out_tag,   64'd0);
        rst = 1'b0;
        check_eq("rst_in_ready",  64'(bus.in_ready), 64'd1);

        // Single vectors: latency and contents of each table entry.
        for (int i = 0; i < 6; i++) begin
            timed_send(i, TAG_W'(i + 5), "latency");
        end
        drain("drain_single");

        // Back-to-back stream with wrapping tags.
        base = n_results;
        for (int i = 0; i < 20; i++) begin
            send(i % 6, TAG_W'(i));
        end
        idle();
        drain("drain_stream");
        check_eq("stream_count", 64'(n_results - base), 64'd20);

        // Consumer drops out_ready for five cycles in the middle of a stream.
        base = n_results;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    send((i * 5) % 6, TAG_W'(i + 3));
                end
                idle();
            end
            stall_test(base);
        join
        drain("drain_stall");
        check_eq("stall_count", 64'(n_results - base), 64'd16);

        // Reset with the pipe full of vectors.
        for (int i = 0; i < 24; i++) begin
            send(i % 6, TAG_W'(i));
        end
        idle();
        check_eq("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("midrst_out_vec",   bus.out_vec,   64'd0);
        check_eq("midrst_out_scale", bus.out_scale, 64'd0);
        check_eq("midrst_out_zero",  64'(bus.out_zero), 64'd0);
        check_eq("midrst_out_tag",   bus.out_tag,   64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) stale++;
        end
        check_eq("stale_valid", 64'(stale), 64'd0);
        timed_send(4, 4'hA, "latency_after_rst");
        drain("drain_final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vector_normalize_stream.md
# vector_normalize_stream

Streaming, parametrised fixed-point vector normaliser for the vector_math pipeline. For each accepted N-component vector v it finds, MSB-first, the largest positive scalar s such that dot(s·v, s·v) ≤ 1.0 without overflow, then outputs s·v, s and a zero-vector flag. It adds valid/ready handshaking, a tag sideband, configurable width/fraction/dimension and reset, and accepts one vector per cycle.

## Interface
- W, 16: total signed fixed-point width; sign bit included.
- FRAC_W, 8: fraction bits; one = 1 << FRAC_W.
- N, 3: vector components.
- TAG_W, 4: sideband tag width, passed through unchanged.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input vector present.
- in_ready  out  1  block accepts the input this cycle.
- in_vec  in  N×W  signed components, component 0 in the LSBs.
- in_tag  in  TAG_W  sideband.
- out_valid  out  1  result present.
- out_ready  in  1  sink accepts the result.
- out_vec  out  N×W  normalised vector s·v.
- out_scale  out  W  final scalar s, always ≥ 0.
- out_zero  out  1  input was the all-zero vector.
- out_tag  out  TAG_W  tag of that input.

## Operation
- Transfer occurs when valid & ready are both high on a rising edge.
- Multiply rule: (a·b) >>> FRAC_W, using a 2W-bit signed product truncated toward −inf. The result overflows if it falls outside the signed W-bit range.
- Dot product: sum of the N truncated squares, accumulated in W+clog2(N) bits. It overflows if the sum exceeds 2^(W−1)−1.
- Search runs over W−1 stages, g = 0..W−2, with test bit t_g = 1 << (W−2−g).
  - Candidate c = s_g | t_g.
  - Keep the bit (s_{g+1} = c) iff no component multiply overflows, no dot overflow occurs, and dot ≤ one. Otherwise s_{g+1} = s_g.
- Start value s_0 = 0. The sign bit is never set.
- Output stage: out_vec = s_{W−1}·v (cannot overflow) and out_scale = s_{W−1}.
- Zero vector: every candidate is accepted, so out_scale = 2^(W−1)−1, out_vec = 0 and out_zero = 1. out_zero is computed at input and carried down the pipe.
- Large |v| gives coarse s. This is accepted behaviour; no saturation flag is produced.
- Each stage register holds valid, v, s_g and tag.
- advance = ~out_valid | out_ready.
  - All stages shift only when advance is high.
  - Bubbles are not compressed.
- in_ready = advance.

## Timing
- Latency: a vector accepted at edge t gives out_valid high after edge t+W, i.e. W−1 search registers plus the output register. No stall is assumed.
- Throughput: one vector per cycle while out_ready = 1.
- Stall: while out_valid & ~out_ready, every register holds and outputs stay stable. in_ready is low in the same cycle (combinational).
- Reset, asserted at any time including mid-stream:
  - All valid bits clear immediately.
  - out_valid = 0, out_vec = 0, out_scale = 0, out_zero = 0, out_tag = 0.
  - In-flight vectors are discarded.
- First accept is possible on the first edge after rst deasserts.
- in_valid low on an advancing edge inserts a bubble: stage valid = 0, data is don't-care.

## Configuration
- VECTOR_NORMALIZE_STREAM_BACKPRESSURE_EN
  - Defined: out_ready is honoured and the advance/stall rules above apply.
  - Undefined: out_ready is ignored, advance = 1 and in_ready is tied to 1. The pipeline free-runs and a result is presented for exactly one cycle.

## Structure
- Package vector_norm_pkg holds:
  - one(FRAC_W) constant function;
  - fixed multiply-with-overflow function;
  - stage struct typedef {valid, vec, scale, zero, tag}, parametrised through the package's localparam defaults.
- Shared fixed-point types stay in the existing fixed_point package.
- One sub-module: vnorm_stage. It holds one search stage (candidate multiply, dot product, compare, register) and has a test-bit parameter. It is instantiated W−1 times by generate.

## Test plan
All scenarios use W=16, FRAC_W=8, N=3.
- Basic: v = (0x0300, 0x0400, 0) → out_scale 0x0033, out_vec (0x0099, 0x00CC, 0x0000), out_zero 0; out_valid exactly 16 cycles after accept.
- Sign and unit: v = (0xFD00, 0x0400, 0) → out_vec (0xFF67, 0x00CC, 0). v = (0x0100, 0, 0) → scale 0x0100, out_vec (0x0100, 0, 0).
- Zero and large: v = 0 → scale 0x7FFF, out_vec 0, out_zero 1. v = (0x6400, 0, 0) → scale 0x0002, out_vec (0x00C8, 0, 0).
- Streaming: 20 back-to-back vectors with tags 0..15 wrapping, out_ready = 1 → 20 consecutive results in order, tags matching.
- Backpressure (macro defined): drop out_ready for 5 cycles mid-stream → in_ready low, outputs stable, no loss or duplication. Macro undefined: in_ready stays 1 and results appear regardless of out_ready.
- Reset: assert rst with 8 vectors in flight → outputs zero immediately; after release, no stale out_valid and the next vector has latency 16.
